// File: rtl/pipe_credit_buffer_pkg.sv
// Shared defaults for the credit-controlled result buffer slice.
package pipe_credit_buffer_pkg;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_DEPTH   = 8;
    localparam int unsigned DEF_LATENCY = 4;

endpackage

// File: rtl/pipe_credit_buffer_if.sv
// Issue, pipeline-result and consumer handshakes of the credit buffer.
interface pipe_credit_buffer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             issue_valid;
    logic             issue_ready;
    logic             pipe_valid;
    logic [WIDTH-1:0] pipe_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output issue_valid, pipe_valid, pipe_data, out_ready,
        input  issue_ready, out_valid, out_data
    );

    modport slave (
        input  issue_valid, pipe_valid, pipe_data, out_ready,
        output issue_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_credit_buffer_sync_fifo.sv
// Result storage: circular buffer with wrapping pointers and occupancy count.
module sync_fifo
    import pipe_credit_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic             wr_en;
    logic             rd_en;

    always_comb begin
        full       = (count == CNT_W'(DEPTH));
        empty      = (count == '0);
        rd_en      = pop && !empty;
        wr_en      = push && (!full || rd_en);
        wr_ptr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
        rd_ptr_nxt = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
        // Storage is not reset, so the head is masked whenever nothing is valid.
        pop_data   = empty ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr_nxt;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pipe_credit_buffer.sv
// Credit gate in front of a fixed-latency, non-stalling pipeline, with a
// result buffer that absorbs every result the credits allowed to launch.
module pipe_credit_buffer
    import pipe_credit_buffer_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned LATENCY = DEF_LATENCY
) (
    input  logic                         clk,
    input  logic                         rst,
    pipe_credit_buffer_if.slave          bus,
    output logic [$clog2(DEPTH+1)-1:0]   credits_used,
    output logic                         err
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 2 || LATENCY < 1) begin : g_bad_params
        $error("pipe_credit_buffer: DEPTH must be >= 2 and LATENCY >= 1");
    end

    logic             issue_fire;
    logic             pop;
    logic             push;
    logic             accept;
    logic             inflight_nz;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] occupancy;
    logic [WIDTH-1:0] head_data;

    always_comb begin
        bus.issue_ready = (credits_used < CNT_W'(DEPTH)) && !rst;
        bus.out_valid   = !empty;
        bus.out_data    = head_data;
        issue_fire      = bus.issue_valid && bus.issue_ready;
        pop             = !empty && bus.out_ready;
        inflight_nz     = (credits_used > occupancy);
        // A full buffer takes a result only into the slot its same-cycle pop
        // frees; otherwise a result is legal only while one is still owed.
        accept          = full ? pop : inflight_nz;
        push            = bus.pipe_valid && accept;
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.pipe_data),
        .pop       (pop),
        .pop_data  (head_data),
        .full      (full),
        .empty     (empty),
        .count     (occupancy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_used <= '0;
        end else begin
            case ({issue_fire, pop})
                2'b10:   credits_used <= credits_used + CNT_W'(1);
                2'b01:   credits_used <= credits_used - CNT_W'(1);
                default: credits_used <= credits_used;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (bus.pipe_valid && !accept) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_credit_buffer.sv
// Scoreboard bench: a 4-stage delay of issue fire stands in for the upstream pipeline.
module tb_pipe_credit_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  credits_used;
    logic        err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [31:0] sb [$];
    logic [3:0]  pv;
    logic [31:0] pd [4];
    logic        inj_valid = 1'b0;
    logic [31:0] inj_data  = '0;
    int unsigned seq = 0;
    int unsigned issue_count = 0;
    int unsigned pop_count = 0;
    logic        fire;
    logic        pop_now;

    pipe_credit_buffer_if #(.WIDTH(32)) bus ();

    pipe_credit_buffer #(
        .WIDTH   (32),
        .DEPTH   (8),
        .LATENCY (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .credits_used (credits_used),
        .err          (err)
    );

    always #5 clk = ~clk;

    assign fire           = bus.issue_valid && bus.issue_ready;
    assign pop_now        = bus.out_valid && bus.out_ready;
    assign bus.pipe_valid = pv[3] | inj_valid;
    assign bus.pipe_data  = inj_valid ? inj_data : pd[3];

    function automatic logic [31:0] tag_of(int unsigned n);
        return (32'(n) * 32'h9E37_79B1) ^ 32'h5A00_0001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Upstream pipeline model; it shares rst with the DUT.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0;
            sb.delete();
        end else begin
            pv    <= {pv[2:0], fire};
            pd[0] <= tag_of(seq);
            pd[1] <= pd[0];
            pd[2] <= pd[1];
            pd[3] <= pd[2];
            if (fire) begin
                sb.push_back(tag_of(seq));
                seq         <= seq + 1;
                issue_count <= issue_count + 1;
            end
            if (pop_now) begin
                pop_count <= pop_count + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && pop_now) begin
            if (sb.size() == 0) begin
                chk("pop_underflow", 32'd1, 32'd0);
            end else begin
                chk("pop_data", bus.out_data, sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.issue_valid = 1'b0;
        bus.out_ready   = 1'b0;
        inj_valid       = 1'b0;
        rst             = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic fill();
        bus.issue_valid = 1'b1;
        bus.out_ready   = 1'b0;
        repeat (20) tick();
        bus.issue_valid = 1'b0;
    endtask

    task automatic drain();
        bus.issue_valid = 1'b0;
        bus.out_ready   = 1'b1;
        for (int i = 0; i < 64 && credits_used != 0; i++) tick();
        bus.out_ready = 1'b0;
        chk("drain_credits", 32'(credits_used), 32'd0);
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned full_at;
        int unsigned p0;
        int unsigned i0;
        int unsigned max_cred;

        bus.issue_valid = 1'b0;
        bus.out_ready   = 1'b0;
        #3;
        chk("rst_issue_ready", 32'(bus.issue_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_credits", 32'(credits_used), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_issue_ready", 32'(bus.issue_ready), 32'd1);
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

        // Fill with out_ready low: eight launches, then the credit gate closes.
        bus.issue_valid = 1'b1;
        full_at = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 4) chk("no_bypass_out_valid", 32'(bus.out_valid), 32'd0);
            if (i == 5) begin
                chk("first_out_valid", 32'(bus.out_valid), 32'd1);
                chk("first_head_data", bus.out_data, sb[0]);
            end
            if (!bus.issue_ready && full_at == 0) full_at = i;
        end
        chk("fill_full_cycle", full_at, 32'd8);
        chk("fill_issue_count", issue_count, 32'd8);
        chk("fill_credits", 32'(credits_used), 32'd8);
        chk("fill_err", 32'(err), 32'd0);

        // Full buffer: a result and a pop in the same cycle are both taken.
        bus.issue_valid = 1'b0;
        bus.out_ready   = 1'b1;
        inj_valid       = 1'b1;
        inj_data        = 32'hA5A5_A5A5;
        sb.push_back(32'hA5A5_A5A5);
        tick();
        inj_valid = 1'b0;
        chk("fullpop_credits", 32'(credits_used), 32'd7);
        chk("fullpop_err", 32'(err), 32'd0);
        repeat (7) tick();
        bus.out_ready = 1'b0;
        chk("fullpop_tail_valid", 32'(bus.out_valid), 32'd1);
        chk("fullpop_tail_data", bus.out_data, 32'hA5A5_A5A5);
        chk("fullpop_sb_left", 32'(sb.size()), 32'd1);
        do_reset();

        // Drain a full buffer while issuing: one item per cycle in steady state.
        fill();
        bus.issue_valid = 1'b1;
        bus.out_ready   = 1'b1;
        tick();
        chk("pop_reenables_issue", 32'(bus.issue_ready), 32'd1);
        chk("pop_credits", 32'(credits_used), 32'd7);
        p0 = pop_count;
        i0 = issue_count;
        repeat (30) tick();
        chk("steady_pops", pop_count - p0, 32'd30);
        chk("steady_issues", issue_count - i0, 32'd30);
        chk("steady_credits", 32'(credits_used), 32'd7);
        drain();
        do_reset();

        // Result arriving at a full buffer with no pop is dropped.
        fill();
        inj_valid = 1'b1;
        inj_data  = 32'hDEAD_BEEF;
        tick();
        inj_valid = 1'b0;
        chk("overflow_err", 32'(err), 32'd1);
        chk("overflow_credits", 32'(credits_used), 32'd8);
        drain();
        chk("overflow_dropped", 32'(bus.out_valid), 32'd0);
        chk("overflow_err_sticky", 32'(err), 32'd1);
        do_reset();
        chk("err_cleared_by_rst", 32'(err), 32'd0);

        // Spurious result with no credits outstanding.
        inj_valid = 1'b1;
        inj_data  = 32'h1234_5678;
        tick();
        inj_valid = 1'b0;
        chk("spurious_err", 32'(err), 32'd1);
        chk("spurious_credits", 32'(credits_used), 32'd0);
        tick();
        chk("spurious_dropped", 32'(bus.out_valid), 32'd0);
        repeat (5) tick();
        chk("spurious_err_sticky", 32'(err), 32'd1);
        do_reset();

        // Asynchronous reset with 3 in flight and 2 buffered.
        bus.issue_valid = 1'b1;
        repeat (2) tick();
        bus.issue_valid = 1'b0;
        repeat (5) tick();
        bus.issue_valid = 1'b1;
        repeat (3) tick();
        bus.issue_valid = 1'b0;
        chk("pre_rst_credits", 32'(credits_used), 32'd5);
        chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_credits", 32'(credits_used), 32'd0);
        chk("async_rst_issue_ready", 32'(bus.issue_ready), 32'd0);
        chk("async_rst_out_data", bus.out_data, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rel_issue_ready", 32'(bus.issue_ready), 32'd1);
        chk("rel_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (10) tick();
        chk("rst_discard_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_discard_err", 32'(err), 32'd0);
        do_reset();

        // Random traffic.
        max_cred = 0;
        for (int i = 0; i < 10000; i++) begin
            bus.issue_valid = 1'($urandom_range(0, 1));
            bus.out_ready   = 1'($urandom_range(0, 1));
            tick();
            if (32'(credits_used) > max_cred) max_cred = 32'(credits_used);
        end
        chk("rand_credit_bound", 32'(max_cred <= 8), 32'd1);
        chk("rand_err", 32'(err), 32'd0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_credit_buffer.md
PIPE_CREDIT_BUFFER -- requirements
Module: pipe_credit_buffer

Interface
REQ-001 Parameter WIDTH, default 32: data width of pipeline results.
REQ-002 Parameter DEPTH, default 8: result buffer entries, equal to the total credit count.
REQ-003 Parameter LATENCY, default 4: fixed cycle latency of the upstream non-stalling pipeline (informational; not used in logic).
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 issue_valid  in  1  producer requests to launch one item into the upstream fixed-latency pipeline.
REQ-007 issue_ready  out  1  a credit is available; launch is permitted.
REQ-008 pipe_valid  in  1  result arriving from the pipeline this cycle.
REQ-009 pipe_data  in  WIDTH  result payload qualified by pipe_valid.
REQ-010 out_valid  out  1  buffer head is valid.
REQ-011 out_ready  in  1  consumer accepts the head.
REQ-012 out_data  out  WIDTH  buffer head payload.
REQ-013 credits_used  out  $clog2(DEPTH+1)  items in flight plus items buffered.
REQ-014 err  out  1  sticky protocol error flag.

Function
REQ-015 Issue fires when issue_valid && issue_ready; pop fires when out_valid && out_ready.
REQ-016 issue_ready SHALL be (credits_used < DEPTH) && !rst, derived from registered state only, with no combinational path from any input.
REQ-017 credits_used SHALL change as follows: +1 on issue only, -1 on pop only, unchanged when both or neither fire.
REQ-018 occupancy: +1 on an accepted pipe_valid write, -1 on pop; inflight = credits_used - occupancy.
REQ-019 Write on pipe_valid goes to the tail; out_valid asserts the cycle after the write (1-cycle latency, no same-cycle bypass), including when the buffer is empty.
REQ-020 FIFO order SHALL be strict; read and write pointers wrap modulo DEPTH.
REQ-021 Full with pipe_valid and pop in the same cycle: both accepted, occupancy unchanged.
REQ-022 pipe_valid with inflight == 0 (spurious result) or with the buffer full and no pop: data dropped, counters unchanged, err set.
REQ-023 Pop with the buffer empty cannot occur, because out_valid is 0.
REQ-024 out_data SHALL hold stable while out_valid && !out_ready.
REQ-025 err SHALL clear only on reset.

Reset
REQ-026 On rst assertion, asynchronously clear: credits_used=0, occupancy=0, pointers=0, out_valid=0, err=0; issue_ready=0 while rst is high.
REQ-027 First cycle after deassertion: issue_ready=1, out_valid=0.
REQ-028 Reset mid-operation discards in-flight and buffered items; the upstream pipeline SHALL be reset by the same rst.
REQ-029 Buffer storage (payload RAM) need not be reset; out_data SHALL be 0 while out_valid=0 after reset.

Structure
REQ-030 The shared package SHALL hold no typedefs; CNT_W = $clog2(DEPTH+1) and PTR_W = $clog2(DEPTH) are local parameters.
REQ-031 Storage and pointers SHALL be one sub-module, sync_fifo (WIDTH, DEPTH), with push/pop/full/empty ports and async reset.
REQ-032 The credit counter and err logic SHALL reside in pipe_credit_buffer.

Verification (DEPTH=8, LATENCY=4, upstream modelled by a 4-stage delay of issue fire)
REQ-033 Hold issue_valid=1 and out_ready=0 -> exactly 8 issues, issue_ready=0 from cycle 8, credits_used=8, 8 results buffered, err=0.
REQ-034 Then set out_ready=1 -> out_data yields 8 results in issue order; each pop re-enables one issue; the steady state sustains 1 item/cycle.
REQ-035 Buffer full, pipe_valid=1 (data 0xA5A5A5A5) plus pop in the same cycle -> both accepted, occupancy stays 8, err=0.
REQ-036 Inject pipe_valid with credits_used=0 -> data dropped, err=1 and stays 1 until rst.
REQ-037 Assert rst asynchronously with 3 in flight and 2 buffered -> out_valid=0, credits_used=0 immediately; issue_ready=1 the cycle after deassertion.
REQ-038 Random issue_valid/out_ready (50%) for 10,000 cycles -> scoreboard order match, err=0, credits_used never exceeds 8.
